mux_serializer16: RTL and testbench

MUX_SERIALIZER16 -- requirements
Module: mux_serializer16

---
 rtl/mux_serializer16_pkg.sv | 17 +
 rtl/mux_serializer16_bit_select16.sv | 19 +
 rtl/mux_serializer16.sv | 124 ++++++++++++
 tb/tb_mux_serializer16.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_serializer16_pkg.sv
// rtl/mux_serializer16_pkg.sv - shared types and widths for the 16-bit word serializer
// Purpose: state encoding and word/index widths used by the serializer and its bit selector.
// Ports: none (package).
package mux_serializer16_pkg;

  localparam int WORD_W = 16;
  localparam int SEL_W  = 4;

  // Index of the final bit in a word; ends the word and opens the load window.
  localparam logic [SEL_W-1:0] SEL_MAX = 4'd15;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/mux_serializer16_bit_select16.sv
// rtl/mux_serializer16_bit_select16.sv - combinational 16:1 bit multiplexer
// Purpose: pick one bit of a 16-bit word by physical bit index.
// Ports:
//   data_in  in  16  word to select from
//   sel_in   in  4   physical bit index
//   bit_out  out 1   selected bit
module bit_select16
  import mux_serializer16_pkg::*;
(
  input  logic [WORD_W-1:0] data_in,
  input  logic [SEL_W-1:0]  sel_in,
  output logic              bit_out
);

  always_comb begin
    bit_out = data_in[sel_in];
  end

endmodule

// File: rtl/mux_serializer16.sv
// rtl/mux_serializer16.sv - 16-bit parallel-to-serial converter with ready/valid on both sides
// Purpose: accept a 16-bit word, send it one bit per transfer in a selectable order, and
//          count completed words. Back-to-back words stream without a bubble.
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      upstream word available
//   in_ready   out  1      word accepted this cycle when in_valid is also high
//   in_data    in   16     parallel word, sampled only on accept
//   ser_valid  out  1      ser_data holds a valid bit
//   ser_ready  in   1      downstream consumes the bit this cycle
//   ser_data   out  1      current serial bit
//   ser_last   out  1      current bit is the last of its word
//   sel        out  4      bit index in send order
//   busy       out  1      word in flight
//   word_count out  CNT_W  completed words, wraps
module mux_serializer16
  import mux_serializer16_pkg::*;
#(
  parameter int MSB_FIRST = 0,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_data,
  output logic              ser_last,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic [CNT_W-1:0]  word_count
);

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  hold_q, hold_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   word_count_q, word_count_d;

  logic [SEL_W-1:0]   bit_idx;
  logic               sel_bit;
  logic               in_shift;
  logic               at_last;
  logic               bit_xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      sel_q        <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      sel_q        <= sel_d;
      word_count_q <= word_count_d;
    end
  end

  // Send order is mapped to a physical bit index here so the selector stays order-agnostic.
  always_comb begin
    bit_idx = (MSB_FIRST != 0) ? (SEL_MAX - sel_q) : sel_q;
  end

  bit_select16 u_bit_select (
    .data_in (hold_q),
    .sel_in  (bit_idx),
    .bit_out (sel_bit)
  );

  always_comb begin
    in_shift = (state_q == SHIFT);
    at_last  = (sel_q == SEL_MAX);
    bit_xfer = in_shift && ser_ready;

    // The last bit's transfer doubles as the load slot for the next word, so in_ready
    // follows ser_ready combinationally there to avoid a bubble between words.
    in_ready   = !in_shift || (at_last && ser_ready);
    ser_valid  = in_shift;
    ser_data   = in_shift && sel_bit;
    ser_last   = in_shift && at_last;
    sel        = sel_q;
    busy       = in_shift;
    word_count = word_count_q;
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    sel_d        = sel_q;
    word_count_d = word_count_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          hold_d  = in_data;
          sel_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_xfer) begin
          if (!at_last) begin
            sel_d = sel_q + 4'd1;
          end else begin
            word_count_d = word_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            sel_d        = '0;
            if (in_valid) begin
              hold_d = in_data;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_serializer16.sv
// tb/tb_mux_serializer16.sv - directed self-checking bench for mux_serializer16
module tb_mux_serializer16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        ser_ready;

  logic        in_ready, ser_valid, ser_data, ser_last, busy;
  logic [3:0]  sel;
  logic [7:0]  word_count;

  logic        in_ready_m, ser_valid_m, ser_data_m, ser_last_m, busy_m;
  logic [3:0]  sel_m;
  logic [7:0]  word_count_m;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_serializer16 #(.MSB_FIRST(0), .CNT_W(8)) dut_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .ser_data   (ser_data),
    .ser_last   (ser_last),
    .sel        (sel),
    .busy       (busy),
    .word_count (word_count)
  );

  mux_serializer16 #(.MSB_FIRST(1), .CNT_W(8)) dut_msb (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready_m),
    .in_data    (in_data),
    .ser_valid  (ser_valid_m),
    .ser_ready  (ser_ready),
    .ser_data   (ser_data_m),
    .ser_last   (ser_last_m),
    .sel        (sel_m),
    .busy       (busy_m),
    .word_count (word_count_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input logic [15:0] w, input int i, input logic exp_ready);
    logic [3:0] idx;
    idx = 4'(i);
    chk("ser_valid", {31'd0, ser_valid}, 32'd1);
    chk("sel", {28'd0, sel}, {28'd0, idx});
    chk("ser_data_lsb", {31'd0, ser_data}, {31'd0, w[idx]});
    chk("ser_data_msb", {31'd0, ser_data_m}, {31'd0, w[4'd15 - idx]});
    chk("ser_last", {31'd0, ser_last}, {31'd0, (i == 15)});
    chk("ser_last_msb", {31'd0, ser_last_m}, {31'd0, (i == 15)});
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    chk("busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic check_idle(input logic [7:0] exp_wc);
    chk("idle_ser_valid", {31'd0, ser_valid}, 32'd0);
    chk("idle_ser_data", {31'd0, ser_data}, 32'd0);
    chk("idle_ser_last", {31'd0, ser_last}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("word_count", {24'd0, word_count}, {24'd0, exp_wc});
    chk("word_count_msb", {24'd0, word_count_m}, {24'd0, exp_wc});
  endtask

  // Accept one word from IDLE, then send it with ser_ready high (optional stall at bit 5).
  task automatic send_word(input logic [15:0] w, input bit stall);
    in_valid = 1'b1;
    in_data  = w;
    ser_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = 16'hDEAD;
    for (int i = 0; i < 16; i++) begin
      if (stall && i == 5) begin
        ser_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          check_bit(w, 5, 1'b0);
          tick();
        end
        ser_ready = 1'b1;
      end
      #1;
      check_bit(w, i, (i == 15));
      tick();
    end
    #1;
  endtask

  initial begin
    logic [15:0] cur;
    logic [15:0] nxt;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    ser_ready = 1'b0;
    #1;
    check_idle(8'd0);
    chk("reset_sel", {28'd0, sel}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check_idle(8'd0);
    tick();

    // Junk on in_data without in_valid must not start anything.
    in_data = 16'h1234;
    tick();
    #1;
    check_idle(8'd0);
    tick();

    send_word(16'hA5C3, 1'b0);
    check_idle(8'd1);
    tick();

    send_word(16'h8001, 1'b0);
    check_idle(8'd2);
    tick();

    send_word(16'h0020, 1'b1);
    check_idle(8'd3);
    tick();

    // Two words back to back with in_valid held; second accepted on bit 15 of the first.
    in_valid  = 1'b1;
    in_data   = 16'hFFFF;
    ser_ready = 1'b1;
    tick();
    in_data = 16'h0000;
    for (int i = 0; i < 32; i++) begin
      if (i == 31) in_valid = 1'b0;
      #1;
      check_bit((i < 16) ? 16'hFFFF : 16'h0000, i % 16, (i == 15) || (i == 31));
      tick();
    end
    #1;
    check_idle(8'd5);
    tick();

    // Reset mid-word at sel=7.
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #1;
    chk("pre_reset_sel", {28'd0, sel}, 32'd7);
    rst_n = 1'b0;
    #1;
    check_idle(8'd0);
    chk("rst_sel", {28'd0, sel}, 32'd0);
    chk("rst_ser_valid_msb", {31'd0, ser_valid_m}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check_idle(8'd0);
    tick();
    send_word(16'h0F0F, 1'b0);
    check_idle(8'd1);

    // Counter wrap over 256 streamed words, from a fresh reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cur = 16'h1357;
    in_valid  = 1'b1;
    in_data   = cur;
    ser_ready = 1'b1;
    tick();
    for (int k = 0; k < 256; k++) begin
      nxt = cur + 16'h2B49;
      for (int i = 0; i < 16; i++) begin
        if (i == 15) begin
          in_data = nxt;
          if (k == 255) in_valid = 1'b0;
        end
        #1;
        chk("bulk_ser_valid", {31'd0, ser_valid}, 32'd1);
        chk("bulk_ser_data", {31'd0, ser_data}, {31'd0, cur[i]});
        tick();
      end
      cur = nxt;
      if (k == 254) begin
        #1;
        chk("wc_255", {24'd0, word_count}, 32'd255);
      end
      if (k == 255) begin
        #1;
        chk("wc_wrap", {24'd0, word_count}, 32'd0);
        chk("wrap_idle", {31'd0, ser_valid}, 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
